// File: rtl/alu_seq_ctrl_pkg.sv
// Shared types and defaults for the ALU sequencer: opcodes, FSM state codes
// and the mapping from requested opcode to the command actually sent to the ALU.
package alu_seq_ctrl_pkg;

    localparam int DW_DEF    = 8;
    localparam int CNT_W_DEF = 3;

    typedef enum logic [2:0] {
        OP_PASS   = 3'b000,
        OP_UNDEF  = 3'b001,
        OP_AND    = 3'b010,
        OP_ADD    = 3'b011,
        OP_SHIFT  = 3'b100,
        OP_SET    = 3'b101,
        OP_XOR    = 3'b110,
        OP_BRANCH = 3'b111
    } alu_op_e;

    // State codes are plain constants so they stay readable in older tools and waveforms.
    typedef logic [1:0] seq_state_e;
    localparam seq_state_e ST_IDLE  = 2'd0;
    localparam seq_state_e ST_EXEC  = 2'd1;
    localparam seq_state_e ST_SHIFT = 2'd2;
    localparam seq_state_e ST_DONE  = 2'd3;

    // The undefined opcode is run as a pass-A so the ALU never sees it.
    function automatic logic [2:0] exec_cmd(input logic [2:0] op);
        return (op == OP_UNDEF) ? OP_PASS : op;
    endfunction

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Bundle of request, ALU and response signals around the sequencer.
// slave  = the sequencer itself; master = everything around it (decode, ALU, consumer).
interface alu_seq_ctrl_if #(
    parameter int DW    = alu_seq_ctrl_pkg::DW_DEF,
    parameter int CNT_W = alu_seq_ctrl_pkg::CNT_W_DEF
);
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_op;
    logic [DW-1:0]    req_a;
    logic [DW-1:0]    req_b;
    logic [CNT_W-1:0] req_cnt;
    logic             req_left;
    logic             req_pari;
    logic             req_cin;
    logic             req_bctl;

    logic [2:0]       alu_cmd;
    logic [DW-1:0]    alu_a;
    logic [DW-1:0]    alu_b;
    logic             alu_sc_i;
    logic             alu_left;
    logic             alu_pari;
    logic [DW-1:0]    alu_impl1;
    logic [DW-1:0]    alu_impl2;
    logic             alu_bctl;
    logic [DW-1:0]    alu_rslt;
    logic             alu_sc_o;
    logic             alu_zero;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [DW-1:0]    rsp_data;
    logic             rsp_carry;
    logic             rsp_zero;

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_cnt, req_left, req_pari, req_cin, req_bctl,
        output req_ready,
        output alu_cmd, alu_a, alu_b, alu_sc_i, alu_left, alu_pari, alu_impl1, alu_impl2, alu_bctl,
        input  alu_rslt, alu_sc_o, alu_zero,
        output rsp_valid, rsp_data, rsp_carry, rsp_zero,
        input  rsp_ready
    );

    modport master (
        output req_valid, req_op, req_a, req_b, req_cnt, req_left, req_pari, req_cin, req_bctl,
        input  req_ready,
        input  alu_cmd, alu_a, alu_b, alu_sc_i, alu_left, alu_pari, alu_impl1, alu_impl2, alu_bctl,
        output alu_rslt, alu_sc_o, alu_zero,
        input  rsp_valid, rsp_data, rsp_carry, rsp_zero,
        output rsp_ready
    );

endinterface

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle sequencer in front of the combinational 8-bit ALU. Takes one request
// at a time, runs shifts as a chain of 1-bit ALU steps, and returns the captured
// result over a valid/ready response.
module alu_seq_ctrl
    import alu_seq_ctrl_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input logic          clk,
    input logic          reset,
    alu_seq_ctrl_if.slave bus
);

    seq_state_e       state;
    logic [2:0]       op_q;
    logic [DW-1:0]    a_q;
    logic [DW-1:0]    work_q;
    logic             carry_q;
    logic             left_q;
    logic             pari_q;
    logic             bctl_q;
    logic [CNT_W-1:0] cnt_q;
    logic [DW-1:0]    data_q;
    logic             rcarry_q;
    logic             rzero_q;
    logic             accept;

    assign bus.req_ready = (state == ST_IDLE) & ~reset;
    assign accept        = bus.req_valid & bus.req_ready;

    assign bus.rsp_valid = (state == ST_DONE);
    assign bus.rsp_data  = data_q;
    assign bus.rsp_carry = rcarry_q;
    assign bus.rsp_zero  = rzero_q;

    // Sequencer FSM: latch the request, step the ALU, capture the result and hold it until taken.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            work_q   <= '0;
            carry_q  <= 1'b0;
            left_q   <= 1'b0;
            pari_q   <= 1'b0;
            bctl_q   <= 1'b0;
            cnt_q    <= '0;
            data_q   <= '0;
            rcarry_q <= 1'b0;
            rzero_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_q    <= bus.req_op;
                        a_q     <= bus.req_a;
                        work_q  <= bus.req_b;
                        carry_q <= bus.req_cin;
                        left_q  <= bus.req_left;
                        pari_q  <= bus.req_pari;
                        bctl_q  <= bus.req_bctl;
                        cnt_q   <= bus.req_cnt;
                        if (bus.req_op == OP_SHIFT) begin
                            if (bus.req_cnt == '0) begin
                                data_q   <= bus.req_b;
                                rcarry_q <= 1'b0;
                                rzero_q  <= 1'b0;
                                state    <= ST_DONE;
                            end else begin
                                state <= ST_SHIFT;
                            end
                        end else begin
                            state <= ST_EXEC;
                        end
                    end
                end
                ST_EXEC: begin
                    data_q   <= bus.alu_rslt;
                    rcarry_q <= 1'b0;
                    rzero_q  <= (op_q == OP_BRANCH) & bus.alu_zero;
                    state    <= ST_DONE;
                end
                ST_SHIFT: begin
                    work_q  <= bus.alu_rslt;
                    carry_q <= bus.alu_sc_o;
                    cnt_q   <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        data_q   <= bus.alu_rslt;
                        rcarry_q <= bus.alu_sc_o;
                        rzero_q  <= 1'b0;
                        state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.rsp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // ALU drive: only EXEC and SHIFT present operands; every other state parks the ALU at pass-A of zero.
    always_comb begin
        bus.alu_cmd   = OP_PASS;
        bus.alu_a     = '0;
        bus.alu_b     = '0;
        bus.alu_sc_i  = 1'b0;
        bus.alu_left  = 1'b0;
        bus.alu_pari  = 1'b0;
        bus.alu_impl1 = '0;
        bus.alu_impl2 = '0;
        bus.alu_bctl  = 1'b0;
        case (state)
            ST_EXEC: begin
                bus.alu_cmd   = exec_cmd(op_q);
                bus.alu_a     = a_q;
                bus.alu_b     = work_q;
                bus.alu_sc_i  = carry_q;
                bus.alu_left  = left_q;
                bus.alu_pari  = pari_q;
                bus.alu_impl1 = a_q;
                bus.alu_impl2 = work_q;
                bus.alu_bctl  = bctl_q;
            end
            ST_SHIFT: begin
                bus.alu_cmd   = OP_SHIFT;
                bus.alu_b     = work_q;
                bus.alu_sc_i  = carry_q;
                bus.alu_left  = left_q;
                bus.alu_pari  = pari_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: behavioural ALU on the ALU side, directed and random
// requests, expected responses from an arithmetic reference model.
module tb_alu_seq_ctrl;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    alu_seq_ctrl_if #(.DW(8), .CNT_W(3)) bus ();

    alu_seq_ctrl #(.DW(8), .CNT_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural model of the combinational 8-bit ALU the sequencer drives.
    always_comb begin
        logic fill;
        fill          = bus.alu_pari ? ^bus.alu_b : bus.alu_sc_i;
        bus.alu_rslt  = 8'h00;
        bus.alu_sc_o  = 1'b0;
        case (bus.alu_cmd)
            3'b000: bus.alu_rslt = bus.alu_a;
            3'b010: bus.alu_rslt = bus.alu_a & bus.alu_b;
            3'b011: bus.alu_rslt = bus.alu_a + bus.alu_b;
            3'b100: begin
                if (bus.alu_left) begin
                    bus.alu_rslt = {bus.alu_b[6:0], fill};
                    bus.alu_sc_o = bus.alu_b[7];
                end else begin
                    bus.alu_rslt = {fill, bus.alu_b[7:1]};
                    bus.alu_sc_o = bus.alu_b[0];
                end
            end
            3'b101: bus.alu_rslt = bus.alu_b;
            3'b110: bus.alu_rslt = bus.alu_a ^ bus.alu_b;
            3'b111: bus.alu_rslt = bus.alu_a;
            default: bus.alu_rslt = 8'hxx;
        endcase
        if (bus.alu_cmd == 3'b111) begin
            bus.alu_zero = bus.alu_bctl ? (bus.alu_impl1 == bus.alu_impl2)
                                        : (bus.alu_impl1 != bus.alu_impl2);
        end else begin
            bus.alu_zero = (bus.alu_rslt == 8'h00);
        end
    end

    // Hard stop in case something hangs outside the bounded waits.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Reference: what the sequencer must return, from the operation's definition.
    function automatic void ref_model(input logic [2:0] op, input int a, input int b, input int cnt,
                                      input bit left, input bit pari, input bit cin, input bit bctl,
                                      output int data, output int carry, output int zero, output int lat);
        int v;
        int c;
        int fill;
        carry = 0;
        zero  = 0;
        lat   = 2;
        case (op)
            3'd2:    data = a & b;
            3'd3:    data = (a + b) % 256;
            3'd5:    data = b;
            3'd6:    data = a ^ b;
            3'd7: begin
                data = a;
                zero = bctl ? int'(a == b) : int'(a != b);
            end
            3'd4: begin
                v = b;
                c = cin;
                for (int i = 0; i < cnt; i++) begin
                    fill = pari ? ($countones(v) % 2) : c;
                    if (left) begin
                        c = v / 128;
                        v = (v * 2) % 256 + fill;
                    end else begin
                        c = v % 2;
                        v = v / 2 + fill * 128;
                    end
                end
                data  = v;
                carry = (cnt == 0) ? 0 : c;
                lat   = (cnt == 0) ? 1 : cnt + 1;
            end
            default: data = a;
        endcase
    endfunction

    // One complete transaction: request, wait for the response, optionally stall, then take it.
    task automatic apply_stimulus(input string tag, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                  input int cnt, input bit left, input bit pari, input bit cin, input bit bctl,
                                  input int hold);
        int exp_data, exp_carry, exp_zero, exp_lat;
        int edges;
        int exp_cmd, exp_b;
        ref_model(op, a, b, cnt, left, pari, cin, bctl, exp_data, exp_carry, exp_zero, exp_lat);
        if (op == 3'd4) begin
            exp_cmd = (cnt == 0) ? 0 : 4;
            exp_b   = (cnt == 0) ? 0 : int'(b);
        end else begin
            exp_cmd = (op == 3'd1) ? 0 : int'(op);
            exp_b   = b;
        end

        @(negedge clk);
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_cnt   = 3'(cnt);
        bus.req_left  = left;
        bus.req_pari  = pari;
        bus.req_cin   = cin;
        bus.req_bctl  = bctl;
        bus.req_valid = 1'b1;
        bus.rsp_ready = 1'b0;
        check_output({tag, ".req_ready"}, 32'(bus.req_ready), 32'd1);

        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        edges = 1;
        check_output({tag, ".alu_cmd"}, 32'(bus.alu_cmd), 32'(exp_cmd));
        check_output({tag, ".alu_b"}, 32'(bus.alu_b), 32'(exp_b));

        while (!bus.rsp_valid && edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
        end
        check_output({tag, ".latency"}, 32'(edges), 32'(exp_lat));
        check_output({tag, ".rsp_data"}, 32'(bus.rsp_data), 32'(exp_data));
        check_output({tag, ".rsp_carry"}, 32'(bus.rsp_carry), 32'(exp_carry));
        check_output({tag, ".rsp_zero"}, 32'(bus.rsp_zero), 32'(exp_zero));

        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check_output({tag, ".hold_valid"}, 32'(bus.rsp_valid), 32'd1);
            check_output({tag, ".hold_data"}, 32'(bus.rsp_data), 32'(exp_data));
            check_output({tag, ".hold_req_ready"}, 32'(bus.req_ready), 32'd0);
        end

        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        check_output({tag, ".post_valid"}, 32'(bus.rsp_valid), 32'd0);
        check_output({tag, ".post_req_ready"}, 32'(bus.req_ready), 32'd1);
        check_output({tag, ".post_alu_cmd"}, 32'(bus.alu_cmd), 32'd0);
    endtask

    // Directed scenarios, then a mid-shift reset, then random traffic.
    initial begin
        int seen_valid;
        checks = 0;
        errors = 0;
        bus.req_valid = 1'b0;
        bus.req_op    = 3'd0;
        bus.req_a     = 8'h00;
        bus.req_b     = 8'h00;
        bus.req_cnt   = 3'd0;
        bus.req_left  = 1'b0;
        bus.req_pari  = 1'b0;
        bus.req_cin   = 1'b0;
        bus.req_bctl  = 1'b0;
        bus.rsp_ready = 1'b0;
        reset = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check_output("reset.req_ready", 32'(bus.req_ready), 32'd0);
        check_output("reset.rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check_output("reset.alu_cmd", 32'(bus.alu_cmd), 32'd0);
        check_output("reset.rsp_data", 32'(bus.rsp_data), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_output("reset.ready_after", 32'(bus.req_ready), 32'd1);

        apply_stimulus("add", 3'd3, 8'h3C, 8'h05, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        apply_stimulus("shl3", 3'd4, 8'h00, 8'h81, 3, 1'b1, 1'b0, 1'b1, 1'b0, 0);
        apply_stimulus("shr1p", 3'd4, 8'h00, 8'h07, 1, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        apply_stimulus("shr0p", 3'd4, 8'h00, 8'h07, 0, 1'b0, 1'b1, 1'b1, 1'b0, 0);
        apply_stimulus("beq", 3'd7, 8'h55, 8'h55, 0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        apply_stimulus("bne_eq", 3'd7, 8'h55, 8'h55, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        apply_stimulus("bne_ne", 3'd7, 8'h55, 8'h54, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        apply_stimulus("undef", 3'd1, 8'hA7, 8'h19, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        apply_stimulus("xor_zero", 3'd6, 8'h5A, 8'h5A, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        apply_stimulus("xor_hold", 3'd6, 8'hF0, 8'h3C, 0, 1'b0, 1'b0, 1'b0, 1'b0, 3);
        apply_stimulus("shl7", 3'd4, 8'h00, 8'hC3, 7, 1'b1, 1'b1, 1'b0, 1'b0, 0);

        // Abort a 7-step shift partway through its third step.
        @(negedge clk);
        bus.req_op    = 3'd4;
        bus.req_b     = 8'h96;
        bus.req_cnt   = 3'd7;
        bus.req_left  = 1'b1;
        bus.req_pari  = 1'b0;
        bus.req_cin   = 1'b1;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check_output("abort.alu_cmd", 32'(bus.alu_cmd), 32'd0);
        check_output("abort.alu_b", 32'(bus.alu_b), 32'd0);
        check_output("abort.rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check_output("abort.req_ready", 32'(bus.req_ready), 32'd0);
        check_output("abort.rsp_data", 32'(bus.rsp_data), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        seen_valid = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (bus.rsp_valid) seen_valid = 1;
        end
        check_output("abort.no_response", 32'(seen_valid), 32'd0);
        check_output("abort.idle_ready", 32'(bus.req_ready), 32'd1);
        apply_stimulus("add_after", 3'd3, 8'hFF, 8'h02, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0);

        // Random requests across every opcode, count and flag combination.
        for (int n = 0; n < 60; n++) begin
            logic [2:0] r_op;
            logic [7:0] r_a;
            logic [7:0] r_b;
            r_op = 3'($urandom_range(0, 7));
            r_a  = 8'($urandom);
            r_b  = ($urandom_range(0, 3) == 0) ? r_a : 8'($urandom);
            apply_stimulus($sformatf("rnd%0d", n), r_op, r_a, r_b, int'($urandom_range(0, 7)),
                           1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                           int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
